// File: rtl/apb_reg_slave.sv
// APB completer holding the bridge register file: ID, CTRL, W1C STATUS and scratch words.
// Wait states are inserted through PREADY; every state change is qualified by PCLKEN.
module apb_reg_slave #(
  parameter int                   ADDRWIDTH   = 16,
  parameter int                   DATAWIDTH   = 32,
  parameter int                   NUM_REGS    = 8,
  parameter int                   WAIT_CYCLES = 0,
  parameter logic [DATAWIDTH-1:0] ID_VALUE    = 32'hA9B0_0001,
  parameter logic [DATAWIDTH-1:0] CTRL_RESET  = {DATAWIDTH{1'b0}}
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   PCLKEN,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic [ADDRWIDTH-1:0]   PADDR,
  input  logic                   PWRITE,
  input  logic [DATAWIDTH-1:0]   PWDATA,
  input  logic [DATAWIDTH/8-1:0] PSTRB,
  input  logic [2:0]             PPROT,
  output logic [DATAWIDTH-1:0]   PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [DATAWIDTH-1:0]   ctrl_out,
  input  logic [DATAWIDTH-1:0]   status_in
);

  localparam int IDXW  = ADDRWIDTH - 2;
  localparam int STRBW = DATAWIDTH / 8;
  localparam logic [IDXW-1:0] IDX_ID     = IDXW'(0);
  localparam logic [IDXW-1:0] IDX_CTRL   = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_STATUS = IDXW'(2);
  localparam logic [IDXW-1:0] IDX_LIMIT  = IDXW'(NUM_REGS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic logic [DATAWIDTH-1:0] merge_lanes(
    input logic [DATAWIDTH-1:0] old_v,
    input logic [DATAWIDTH-1:0] new_v,
    input logic [STRBW-1:0]     strb
  );
    logic [DATAWIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < STRBW; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  state_t               state_r;
  logic [3:0]           wait_cnt_r;
  logic [IDXW-1:0]      idx_r;
  logic                 write_r;
  logic [DATAWIDTH-1:0] wdata_r;
  logic [STRBW-1:0]     strb_r;
  logic                 err_r;
  logic [DATAWIDTH-1:0] prdata_r;
  logic [DATAWIDTH-1:0] ctrl_r;
  logic [DATAWIDTH-1:0] scratch_r [3:NUM_REGS-1];
  logic                 viol_r;

  logic [IDXW-1:0]      setup_idx_s;
  logic                 setup_err_s;
  logic [DATAWIDTH-1:0] setup_rdata_s;
  logic [DATAWIDTH-1:0] scratch_rd_s;
  logic                 commit_s;
  logic                 viol_set_s;
  logic                 viol_clr_s;
  logic                 unused_s;

  assign unused_s = ^{PADDR[1:0], PPROT[2:1], status_in[0]};

  // Setup-phase decode: error classification and the read value to be registered.
  always_comb begin
    setup_idx_s  = PADDR[ADDRWIDTH-1:2];
    scratch_rd_s = {DATAWIDTH{1'b0}};
    for (int i = 3; i < NUM_REGS; i++) begin
      if (setup_idx_s == IDXW'(i)) begin
        scratch_rd_s = scratch_r[i];
      end
    end
    if (setup_idx_s >= IDX_LIMIT) begin
      setup_err_s = 1'b1;
    end else if (PWRITE && (setup_idx_s == IDX_ID)) begin
      setup_err_s = 1'b1;
    end else if (PWRITE && (setup_idx_s == IDX_CTRL) && !PPROT[0]) begin
      setup_err_s = 1'b1;
    end else begin
      setup_err_s = 1'b0;
    end
    if (setup_err_s || PWRITE) begin
      setup_rdata_s = {DATAWIDTH{1'b0}};
    end else begin
      case (setup_idx_s)
        IDX_ID:     setup_rdata_s = ID_VALUE;
        IDX_CTRL:   setup_rdata_s = ctrl_r;
        IDX_STATUS: setup_rdata_s = {status_in[DATAWIDTH-1:1], viol_r};
        default:    setup_rdata_s = scratch_rd_s;
      endcase
    end
  end

  assign commit_s   = PCLKEN && (state_r == ACCESS) && PSEL && PENABLE &&
                      (wait_cnt_r == 4'd0) && write_r && !err_r;
  // An access phase without a setup, or a setup abandoned mid-access, is a violation.
  assign viol_set_s = PCLKEN && (((state_r == IDLE) && PSEL && PENABLE) ||
                                 ((state_r == ACCESS) && !(PSEL && PENABLE)));
  assign viol_clr_s = commit_s && (idx_r == IDX_STATUS) && strb_r[0] && wdata_r[0];

  // Transfer FSM: setup capture, wait-state countdown, completion and abort.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r    <= IDLE;
      wait_cnt_r <= 4'd0;
      idx_r      <= {IDXW{1'b0}};
      write_r    <= 1'b0;
      wdata_r    <= {DATAWIDTH{1'b0}};
      strb_r     <= {STRBW{1'b0}};
      err_r      <= 1'b0;
      prdata_r   <= {DATAWIDTH{1'b0}};
    end else if (PCLKEN) begin
      case (state_r)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            idx_r      <= setup_idx_s;
            write_r    <= PWRITE;
            wdata_r    <= PWDATA;
            strb_r     <= PSTRB;
            err_r      <= setup_err_s;
            prdata_r   <= setup_rdata_s;
            wait_cnt_r <= 4'(WAIT_CYCLES);
            state_r    <= ACCESS;
          end
        end
        ACCESS: begin
          if (PSEL && PENABLE && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end else begin
            wait_cnt_r <= 4'd0;
            err_r      <= 1'b0;
            prdata_r   <= {DATAWIDTH{1'b0}};
            state_r    <= IDLE;
          end
        end
        default: begin
          wait_cnt_r <= 4'd0;
          err_r      <= 1'b0;
          prdata_r   <= {DATAWIDTH{1'b0}};
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Register file; a violation set takes priority over a same-cycle W1C clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_r <= CTRL_RESET;
      viol_r <= 1'b0;
      for (int i = 3; i < NUM_REGS; i++) begin
        scratch_r[i] <= {DATAWIDTH{1'b0}};
      end
    end else begin
      if (commit_s && (idx_r == IDX_CTRL)) begin
        ctrl_r <= merge_lanes(ctrl_r, wdata_r, strb_r);
      end
      for (int i = 3; i < NUM_REGS; i++) begin
        if (commit_s && (idx_r == IDXW'(i))) begin
          scratch_r[i] <= merge_lanes(scratch_r[i], wdata_r, strb_r);
        end
      end
      if (viol_set_s) begin
        viol_r <= 1'b1;
      end else if (viol_clr_s) begin
        viol_r <= 1'b0;
      end
    end
  end

  assign PREADY   = (state_r == ACCESS) && (wait_cnt_r == 4'd0);
  assign PSLVERR  = PREADY && err_r;
  assign PRDATA   = prdata_r;
  assign ctrl_out = ctrl_r;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: two instances (0 and 3 wait states) checked every cycle
// against a register-level model, plus literal expectations on key transfers.
module tb_apb_reg_slave;

  localparam logic [31:0] ID_V = 32'hA9B0_0001;
  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        hreset;
  logic        pclken;
  logic [1:0]  psel;
  logic        penable;
  logic [15:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] status_in;
  logic [31:0] prdata_w [2];
  logic [1:0]  pready_w;
  logic [1:0]  pslverr_w;
  logic [31:0] ctrl_w [2];

  always #5 clk = ~clk;

  apb_reg_slave #(.WAIT_CYCLES(0)) u_dut0 (
    .HCLK(clk), .HRESET(hreset), .PCLKEN(pclken), .PSEL(psel[0]), .PENABLE(penable),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_w[0]), .PREADY(pready_w[0]), .PSLVERR(pslverr_w[0]),
    .ctrl_out(ctrl_w[0]), .status_in(status_in));

  apb_reg_slave #(.WAIT_CYCLES(3)) u_dut3 (
    .HCLK(clk), .HRESET(hreset), .PCLKEN(pclken), .PSEL(psel[1]), .PENABLE(penable),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_w[1]), .PREADY(pready_w[1]), .PSLVERR(pslverr_w[1]),
    .ctrl_out(ctrl_w[1]), .status_in(status_in));

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  bit toggle = 1'b0;

  bit          exp_ready [2];
  bit          exp_err [2];
  bit          exp_rd_valid [2];
  logic [31:0] exp_rdata [2];
  logic [31:0] exp_ctrl [2];

  logic [31:0] m_ctrl [2];
  logic [31:0] m_scr [2][NR];
  bit          m_viol [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout got=no-completion expected=completion", name);
  endtask

  function automatic int waits_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ctrl[d] = 32'h0000_0000;
      m_viol[d] = 1'b0;
      for (int i = 0; i < NR; i++) m_scr[d][i] = 32'h0000_0000;
      exp_ready[d]    = 1'b0;
      exp_err[d]      = 1'b0;
      exp_rd_valid[d] = 1'b1;
      exp_rdata[d]    = 32'h0000_0000;
      exp_ctrl[d]     = 32'h0000_0000;
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int d, input int idx);
    case (idx)
      0:       return ID_V;
      1:       return m_ctrl[d];
      2:       return {status_in[31:1], m_viol[d]};
      default: return m_scr[d][idx];
    endcase
  endfunction

  task automatic model_write(input int d, input int idx, input logic [31:0] wd, input logic [3:0] strb);
    if (idx == 1) m_ctrl[d] = lanes(m_ctrl[d], wd, strb);
    else if (idx == 2) begin
      if (strb[0] && wd[0]) m_viol[d] = 1'b0;
    end else if (idx >= 3 && idx < NR) m_scr[d][idx] = lanes(m_scr[d][idx], wd, strb);
    exp_ctrl[d] = m_ctrl[d];
  endtask

  task automatic tick(output bit en);
    en = pclken;
    @(posedge clk);
    #1;
    if (toggle) pclken = ~pclken;
    else pclken = 1'b1;
  endtask

  task automatic idle(input int n);
    bit en;
    psel = 2'b00;
    penable = 1'b0;
    repeat (n) tick(en);
  endtask

  // mode 0: normal, 1: drop PSEL before access cycle 'at', 2: assert HRESET at access cycle 'at'
  task automatic xfer(input int d, input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot, input int mode, input int at,
                      output logic [31:0] got_rd, output bit got_err, output int got_waits);
    int idx; bit err; logic [31:0] rd; bit en; int cnt; int acc; int guard;
    idx = int'(addr[15:2]);
    err = (idx >= NR) || (wr && idx == 0) || (wr && idx == 1 && !prot[0]);
    rd  = (err || wr) ? 32'h0000_0000 : model_read(d, idx);
    got_rd = 32'h0000_0000; got_err = 1'b0; got_waits = 0;
    psel = 2'b00; psel[d] = 1'b1; penable = 1'b0;
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = strb; pprot = prot;
    en = 1'b0; guard = 0;
    while (!en && guard < 16) begin tick(en); guard++; end
    if (!en) begin report_timeout("setup"); return; end
    exp_rd_valid[d] = !wr;
    exp_rdata[d]    = rd;
    exp_ready[d]    = (waits_of(d) == 0);
    exp_err[d]      = exp_ready[d] && err;
    penable = 1'b1;
    paddr  = addr ^ 16'h0004;
    pwdata = ~wd;
    cnt = waits_of(d); acc = 0; guard = 0;
    while (guard < 64) begin
      if (mode == 1 && acc == at) psel[d] = 1'b0;
      if (mode == 2 && acc == at) hreset = 1'b1;
      if (pclken && pready_w[d]) begin got_rd = prdata_w[d]; got_err = pslverr_w[d]; end
      else if (pclken) got_waits++;
      tick(en);
      guard++;
      if (mode == 2 && acc == at) begin
        hreset = 1'b0; psel = 2'b00; penable = 1'b0;
        model_reset();
        return;
      end
      if (en) begin
        if (mode == 1 && acc == at) begin
          m_viol[d] = 1'b1;
          exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rd_valid[d] = 1'b1; exp_rdata[d] = 32'h0000_0000;
          psel = 2'b00; penable = 1'b0;
          return;
        end
        if (cnt == 0) begin
          if (wr && !err) model_write(d, idx, wd, strb);
          exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rd_valid[d] = 1'b1; exp_rdata[d] = 32'h0000_0000;
          psel = 2'b00; penable = 1'b0;
          return;
        end
        cnt--;
        acc++;
        exp_ready[d] = (cnt == 0);
        exp_err[d]   = exp_ready[d] && err;
      end
    end
    report_timeout("access");
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_pready", d), 32'(pready_w[d]), 32'(exp_ready[d]));
        check($sformatf("d%0d_pslverr", d), 32'(pslverr_w[d]), 32'(exp_err[d]));
        if (exp_rd_valid[d]) check($sformatf("d%0d_prdata", d), prdata_w[d], exp_rdata[d]);
        check($sformatf("d%0d_ctrl_out", d), ctrl_w[d], exp_ctrl[d]);
      end
    end
  end

  initial begin
    logic [31:0] rd; bit er; int wt;
    hreset = 1'b1; pclken = 1'b1; psel = 2'b00; penable = 1'b0; paddr = 16'h0000;
    pwrite = 1'b0; pwdata = 32'h0000_0000; pstrb = 4'h0; pprot = 3'b000;
    status_in = 32'h5A5A_0F0E;
    model_reset();
    idle(1);
    chk_on = 1'b1;
    idle(2);
    hreset = 1'b0;
    idle(1);
    check("reset_ctrl_out", ctrl_w[0], 32'h0000_0000);

    xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("id_read", rd, 32'hA9B0_0001);
    check("id_read_err", 32'(er), 32'd0);

    xfer(0, 1'b1, 16'h000C, 32'h1234_5678, 4'b0101, 3'b000, 0, 0, rd, er, wt);
    xfer(0, 1'b0, 16'h000C, 32'h0, 4'hF, 3'b000, 0, 0, rd, er, wt);
    check("strobe_read", rd, 32'h0034_0078);
    xfer(0, 1'b1, 16'h0010, 32'hCAFE_BABE, 4'hF, 3'b000, 0, 0, rd, er, wt);
    xfer(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("b2b_read", rd, 32'hCAFE_BABE);
    idle(1);

    xfer(0, 1'b1, 16'h000C, 32'hAAAA_AAAA, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("strb0_err", 32'(er), 32'd0);
    xfer(0, 1'b0, 16'h000C, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("strb0_read", rd, 32'h0034_0078);

    xfer(0, 1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, 0, rd, er, wt);
    check("id_write_err", 32'(er), 32'd1);
    xfer(0, 1'b0, 16'h0000, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("id_after_write", rd, 32'hA9B0_0001);
    xfer(0, 1'b1, 16'h0004, 32'h0000_00A5, 4'hF, 3'b001, 0, 0, rd, er, wt);
    xfer(0, 1'b1, 16'h0004, 32'hFFFF_FFFF, 4'hF, 3'b000, 0, 0, rd, er, wt);
    check("ctrl_unpriv_err", 32'(er), 32'd1);
    xfer(0, 1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("ctrl_unchanged", rd, 32'h0000_00A5);
    xfer(0, 1'b0, 16'h0020, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("oob_rdata", rd, 32'h0000_0000);
    check("oob_err", 32'(er), 32'd1);
    idle(1);

    xfer(0, 1'b1, 16'h0004, 32'h1111_1111, 4'hF, 3'b001, 1, 0, rd, er, wt);
    idle(1);
    xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("status_viol", rd, 32'h5A5A_0F0F);
    xfer(0, 1'b1, 16'h0008, 32'h0000_0001, 4'h1, 3'b000, 0, 0, rd, er, wt);
    xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("status_cleared", rd, 32'h5A5A_0F0E);
    psel = 2'b01; penable = 1'b1;
    tick(er);
    m_viol[0] = 1'b1;
    xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("status_idle_viol", rd, 32'h5A5A_0F0F);
    idle(1);

    toggle = 1'b1;
    xfer(1, 1'b1, 16'h0004, 32'h0000_BEEF, 4'hF, 3'b001, 0, 0, rd, er, wt);
    check("wait_cycles", 32'(wt), 32'd3);
    toggle = 1'b0;
    idle(2);
    xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("wait_ctrl_read", rd, 32'h0000_BEEF);
    idle(1);

    xfer(1, 1'b1, 16'h0004, 32'h1234_5678, 4'hF, 3'b001, 2, 1, rd, er, wt);
    check("rst_ctrl_d1", ctrl_w[1], 32'h0000_0000);
    check("rst_ctrl_d0", ctrl_w[0], 32'h0000_0000);
    xfer(1, 1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, wt);
    check("rst_ctrl_read", rd, 32'h0000_0000);
    idle(2);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
